// File: rtl/instr_cycle_sequencer.sv
// Q1..Q4 instruction-cycle sequencer with branch flush and SLEEP handling.
// Optional instruction-cycle counter is built only when CYCLE_COUNTER_EN is defined.
module instr_cycle_sequencer #(
    parameter int FLUSH_CYCLES = 1,
    parameter int COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               branch_taken,
    input  logic               sleep_req,
    input  logic               wake,
    output logic [1:0]         q_phase,
    output logic               instr_rd_en,
    output logic               incr_pc_en,
    output logic               rd_phase_en,
    output logic               exec_en,
    output logic               wr_phase_en,
    output logic               flush,
    output logic               sleeping,
    output logic [COUNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_SLEEP = 2'd2
    } state_t;

    // Counter holds the number of dead cycles still to go after the current one.
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [1:0] fcnt_q,  fcnt_d;
    logic       cycle_end;

    assign cycle_end = (phase_q == 2'd3);
    assign q_phase   = phase_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            phase_q <= 2'd0;
            fcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q + 2'd1;
        fcnt_d      = fcnt_q;
        instr_rd_en = 1'b0;
        incr_pc_en  = 1'b0;
        rd_phase_en = 1'b0;
        exec_en     = 1'b0;
        wr_phase_en = 1'b0;
        flush       = 1'b0;
        sleeping    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                instr_rd_en = (phase_q == 2'd0);
                incr_pc_en  = (phase_q == 2'd1);
                rd_phase_en = (phase_q == 2'd1);
                exec_en     = (phase_q == 2'd2);
                wr_phase_en = (phase_q == 2'd3);
                // Branch wins over SLEEP; a SLEEP with wake already pending is a NOP.
                if (cycle_end) begin
                    if (branch_taken) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FLUSH_INIT;
                    end else if (sleep_req && !wake) begin
                        state_d = ST_SLEEP;
                    end
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (cycle_end) begin
                    if (fcnt_q == 2'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        fcnt_d = fcnt_q - 2'd1;
                    end
                end
            end
            ST_SLEEP: begin
                sleeping = 1'b1;
                phase_d  = 2'd0;
                if (wake) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                phase_d = 2'd0;
            end
        endcase
    end

`ifdef CYCLE_COUNTER_EN
    logic [COUNT_W-1:0] count_q;

    // Dead cycles count as completed cycles; SLEEP never reaches Q4.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (cycle_end && (state_q != ST_SLEEP)) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    assign cycle_count = count_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// Scoreboard bench for instr_cycle_sequencer: per-clock expected outputs are queued
// from a mode/stimulus script and compared when the DUT presents that clock's outputs.
module tb_instr_cycle_sequencer;

`ifdef CYCLE_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] ph;
        logic [4:0] en;   // {instr_rd, incr_pc, rd_phase, exec, wr_phase}
        logic       fl;
        logic       sl;
        logic [3:0] cnt;
    } obs_t;

    logic clk;
    logic rst;
    logic branch_taken, sleep_req, wake;

    logic [1:0]  q1, q3;
    logic        ird1, inc1, rd1, ex1, wr1, fl1, sl1;
    logic        ird3, inc3, rd3, ex3, wr3, fl3, sl3;
    logic [3:0]  cc1;
    logic [15:0] cc3;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   sel      = 1'b0;
    obs_t exp_q[$];

    instr_cycle_sequencer #(.FLUSH_CYCLES(1), .COUNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .branch_taken(branch_taken), .sleep_req(sleep_req), .wake(wake),
        .q_phase(q1), .instr_rd_en(ird1), .incr_pc_en(inc1), .rd_phase_en(rd1), .exec_en(ex1),
        .wr_phase_en(wr1), .flush(fl1), .sleeping(sl1), .cycle_count(cc1)
    );

    instr_cycle_sequencer #(.FLUSH_CYCLES(3), .COUNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .branch_taken(branch_taken), .sleep_req(sleep_req), .wake(wake),
        .q_phase(q3), .instr_rd_en(ird3), .incr_pc_en(inc3), .rd_phase_en(rd3), .exec_en(ex3),
        .wr_phase_en(wr3), .flush(fl3), .sleeping(sl3), .cycle_count(cc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Expected outputs for one clock given its mode (R=run, F=flush, S=sleep).
    function automatic obs_t mk(input byte m, input logic [1:0] ph, input logic [3:0] cnt);
        obs_t e;
        e = '0;
        e.cnt = CNT_EN ? cnt : 4'd0;
        if (m == "R") begin
            e.ph = ph;
            case (ph)
                2'd0:    e.en = 5'b10000;
                2'd1:    e.en = 5'b01100;
                2'd2:    e.en = 5'b00010;
                default: e.en = 5'b00001;
            endcase
        end else if (m == "F") begin
            e.ph = ph;
            e.fl = 1'b1;
        end else begin
            e.ph = 2'd0;
            e.sl = 1'b1;
        end
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        if (!sel) o = {q1, ird1, inc1, rd1, ex1, wr1, fl1, sl1, cc1};
        else      o = {q3, ird3, inc3, rd3, ex3, wr3, fl3, sl3, cc3[3:0]};
        return o;
    endfunction

    // Stimulus codes: b=branch, s=sleep, x=branch+sleep, S=sleep+wake, w=wake.
    task automatic drive(input byte c);
        branch_taken = (c == "b") || (c == "x");
        sleep_req    = (c == "s") || (c == "x") || (c == "S");
        wake         = (c == "w") || (c == "S");
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(".");
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        obs_t o, e;
        rst = 1'b0;
        drive(".");
        repeat (2) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            exp_q.push_back(mk("R", 2'd0, 4'd0));
            o = sample(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %h required %h", s, o, e);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_sequencing();
        string M, T; byte m; logic [1:0] ph; logic [3:0] cnt; obs_t o, e;
        M = {"RRRR", "RRRR", "RRRR", "RRRR"};
        T = {".bs.", "b...", "s...", "...."};
        do_reset(); sel = 1'b0; ph = 0; cnt = 0;
        for (int i = 0; i < M.len(); i++) begin
            m = M[i];
            exp_q.push_back(mk(m, ph, cnt));
            drive(T[i]);
            #1; o = sample(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sequencing clk %0d: got %h required %h", i, o, e);
            end
            if (m != "S") begin if (ph == 2'd3) cnt = cnt + 4'd1; ph = ph + 2'd1; end else ph = 2'd0;
            @(negedge clk);
        end
        drive(".");
    endtask

    task automatic test_branch();
        string M, T; byte m; logic [1:0] ph; logic [3:0] cnt; obs_t o, e;
        M = {"RRRRRRRR", "FFFF", "RRRR", "FFFF", "RRRR", "FFFF", "RRRR"};
        T = {".......b", "....", "...x", "...s", "...b", "....", "...."};
        do_reset(); sel = 1'b0; ph = 0; cnt = 0;
        for (int i = 0; i < M.len(); i++) begin
            m = M[i];
            exp_q.push_back(mk(m, ph, cnt));
            drive(T[i]);
            #1; o = sample(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL branch1 clk %0d: got %h required %h", i, o, e);
            end
            if (m != "S") begin if (ph == 2'd3) cnt = cnt + 4'd1; ph = ph + 2'd1; end else ph = 2'd0;
            @(negedge clk);
        end
        drive(".");
    endtask

    task automatic test_flush3();
        string M, T; byte m; logic [1:0] ph; logic [3:0] cnt; obs_t o, e;
        M = {"RRRRRRRR", "FFFFFFFFFFFF", "RRRR"};
        T = {".......b", "...b...x...b", "...."};
        do_reset(); sel = 1'b1; ph = 0; cnt = 0;
        for (int i = 0; i < M.len(); i++) begin
            m = M[i];
            exp_q.push_back(mk(m, ph, cnt));
            drive(T[i]);
            #1; o = sample(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL flush3 clk %0d: got %h required %h", i, o, e);
            end
            if (m != "S") begin if (ph == 2'd3) cnt = cnt + 4'd1; ph = ph + 2'd1; end else ph = 2'd0;
            @(negedge clk);
        end
        drive(".");
        sel = 1'b0;
    endtask

    task automatic test_sleep();
        string M, T; byte m; logic [1:0] ph; logic [3:0] cnt; obs_t o, e;
        M = {"RRRR", "SSSSSSSSSSSSSSSSSSSS", "RRRRRRRR"};
        T = {"...s", "......b.....x......w", "........"};
        do_reset(); sel = 1'b0; ph = 0; cnt = 0;
        for (int i = 0; i < M.len(); i++) begin
            m = M[i];
            exp_q.push_back(mk(m, ph, cnt));
            drive(T[i]);
            #1; o = sample(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sleep clk %0d: got %h required %h", i, o, e);
            end
            if (m != "S") begin if (ph == 2'd3) cnt = cnt + 4'd1; ph = ph + 2'd1; end else ph = 2'd0;
            @(negedge clk);
        end
        drive(".");
    endtask

    task automatic test_sleep_wake_nop();
        string M, T; byte m; logic [1:0] ph; logic [3:0] cnt; obs_t o, e;
        M = {"RRRRRRRRRRRR", "SSSS", "RRRR"};
        T = {"...S...S...s", "...w", "...."};
        do_reset(); sel = 1'b0; ph = 0; cnt = 0;
        for (int i = 0; i < M.len(); i++) begin
            m = M[i];
            exp_q.push_back(mk(m, ph, cnt));
            drive(T[i]);
            #1; o = sample(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sleep_nop clk %0d: got %h required %h", i, o, e);
            end
            if (m != "S") begin if (ph == 2'd3) cnt = cnt + 4'd1; ph = ph + 2'd1; end else ph = 2'd0;
            @(negedge clk);
        end
        drive(".");
    endtask

    task automatic test_wrap();
        logic [1:0] ph; logic [3:0] cnt; obs_t o, e;
        do_reset(); sel = 1'b0; ph = 0; cnt = 0;
        for (int i = 0; i < 68; i++) begin
            exp_q.push_back(mk("R", ph, cnt));
            drive(".");
            #1; o = sample(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wrap clk %0d: got %h required %h", i, o, e);
            end
            if (ph == 2'd3) cnt = cnt + 4'd1;
            ph = ph + 2'd1;
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        string T; logic [1:0] ph; logic [3:0] cnt; obs_t o, e;
        T = "...b.";
        do_reset(); sel = 1'b0; ph = 0; cnt = 0;
        for (int i = 0; i < T.len(); i++) begin
            drive(T[i]);
            if (ph == 2'd3) cnt = cnt + 4'd1;
            ph = ph + 2'd1;
            @(negedge clk);
        end
        drive(".");
        // Clock 5: Q2 of the dead cycle.
        exp_q.push_back(mk("F", ph, cnt));
        #1; o = sample(); e = exp_q.pop_front(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL async_pre: got %h required %h", o, e);
        end
        #1 rst = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            exp_q.push_back(mk("R", 2'd0, 4'd0));
            o = sample(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL async_reset dut%0d: got %h required %h", s, o, e);
            end
        end
        sel = 1'b0;
        @(negedge clk);
        exp_q.push_back(mk("R", 2'd0, 4'd0));
        #1; o = sample(); e = exp_q.pop_front(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL async_hold: got %h required %h", o, e);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        drive(".");
        test_reset();
        test_sequencing();
        test_branch();
        test_flush3();
        test_sleep();
        test_sleep_wake_nop();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_cycle_sequencer.md
Name: instr_cycle_sequencer

Overview:
Generates the four-phase (Q1..Q4) instruction-cycle timing that drives the midrange core's fetch, PC-increment, register-read, ALU-execute and write-back steps.
Inserts dead instruction cycles after a taken branch, which gives branches an 8-clock cost at the default setting.
Implements SLEEP entry and wake-up.
Sits beside the instruction decoder, which gates its own enables with this block's phase enables.

Parameters:
FLUSH_CYCLES, 1, number of dead instruction cycles inserted after branch_taken; legal range 1..3.
COUNT_W, 16, width of the instruction-cycle counter.

Ports:
clk  input  1  core clock.
rst  input  1  asynchronous, active-low reset (asserted when 0).
branch_taken  input  1  decoder: the current instruction modified the PC (GOTO/CALL/RETURN/taken skip/PCL write); sampled at Q4.
sleep_req  input  1  decoder: the current instruction is SLEEP; sampled at Q4.
wake  input  1  level-sensitive wake event (interrupt/peripheral).
q_phase  output  2  current phase: 0=Q1, 1=Q2, 2=Q3, 3=Q4.
instr_rd_en  output  1  program memory captures the instruction at the PC.
incr_pc_en  output  1  increment PC.
rd_phase_en  output  1  regfile/peripheral read phase.
exec_en  output  1  ALU/status update phase.
wr_phase_en  output  1  W/regfile write-back phase.
flush  output  1  current instruction cycle is a dead (forced NOP) cycle.
sleeping  output  1  core is in SLEEP.
cycle_count  output  COUNT_W  completed instruction cycles (see Optional Feature).

Behaviour:
- States: RUN, FLUSH, SLEEP. Phase counter is 2 bits; flush counter is 2 bits.
- Reset values (async, while rst=0): state=RUN, q_phase=0, flush=0, sleeping=0, flush counter=0, cycle_count=0. Reset mid-cycle discards all state; the first cycle after release starts at Q1 in RUN.
- RUN and FLUSH: q_phase advances 0→1→2→3→0 on every clk.
- Enable decode, RUN:
  - instr_rd_en=1 when q_phase=0.
  - incr_pc_en=1 when q_phase=1.
  - rd_phase_en=1 when q_phase=1.
  - exec_en=1 when q_phase=2.
  - wr_phase_en=1 when q_phase=3.
- Enable decode, FLUSH and SLEEP: all five enables are 0.
- All outputs are combinational from registered state; there is no added latency.
- At the Q4→Q1 edge in RUN:
  - branch_taken=1 → FLUSH, flush counter=FLUSH_CYCLES-1.
  - Else sleep_req=1 and wake=0 → SLEEP.
  - Else sleep_req=1 and wake=1 → remain in RUN; the SLEEP instruction behaves as a NOP.
  - Else remain in RUN.
- Priority: branch_taken over sleep_req.
- branch_taken and sleep_req are ignored in FLUSH and SLEEP, and at any phase other than Q4.
- FLUSH: flush=1. At each Q4→Q1 edge, if counter=0 go to RUN; otherwise decrement the counter.
- SLEEP: sleeping=1, q_phase held at 0, all enables 0, cycle_count frozen.
  - wake=1 at a clk edge → RUN at Q1 on the next cycle, with normal fetch.
  - wake is level-sensitive; no edge detection.
- flush=1 exactly in FLUSH; sleeping=1 exactly in SLEEP.
- FLUSH_CYCLES outside 1..3 is illegal; the bench checks only legal values.

Optional Feature:
Macro CYCLE_COUNTER_EN.
- Defined: cycle_count increments by 1 at every Q4→Q1 edge in RUN or FLUSH (dead cycles count), never in SLEEP. It wraps from 2^COUNT_W-1 to 0.
- Undefined: no counter register is built and cycle_count is tied to 0.

Test Plan:
- Release reset, no requests → q_phase reads 0,1,2,3,0…; instr_rd_en high on clocks 0,4,8; exec_en on clocks 2,6; flush=0 throughout.
- branch_taken=1 at Q4 of cycle 1, FLUSH_CYCLES=1 → cycle 2 has flush=1 and all enables 0 for 4 clocks; instr_rd_en returns at clock 12; the branch costs 8 clocks.
- FLUSH_CYCLES=3 with branch_taken → 12 dead clocks; branch_taken pulsed during the flush is ignored; the next fetch occurs 16 clocks after the branch instruction's Q1.
- sleep_req=1 at Q4 with wake=0 → sleeping=1, q_phase stuck at 0 for 20 clocks, cycle_count constant. Raising wake → next clock q_phase=0 in RUN with instr_rd_en=1, then normal sequencing.
- sleep_req=1 and wake=1 at the same Q4 → no sleep, sleeping stays 0. Also drive sleep_req=1 and branch_taken=1 together → FLUSH entered, no sleep.
- CYCLE_COUNTER_EN defined, COUNT_W=4 → after 16 cycles cycle_count wraps to 0. Asserting rst=0 at Q2 → all outputs return to their reset values immediately, without waiting for a clock edge.
